// File: rtl/etx_txsched.sv
// Transmit scheduler: arbitrates write, read-request and read-response channels
// into one held output register with separate downstream stalls for reads and writes.
module etx_txsched #(
  parameter int PW      = 104,
  parameter int HOLDMAX = 4
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          txwr_fifo_access,
  input  logic [PW-1:0] txwr_fifo_packet,
  output logic          txwr_fifo_wait,
  input  logic          txrd_fifo_access,
  input  logic [PW-1:0] txrd_fifo_packet,
  output logic          txrd_fifo_wait,
  input  logic          txrr_fifo_access,
  input  logic [PW-1:0] txrr_fifo_packet,
  output logic          txrr_fifo_wait,
  output logic          etx_access,
  output logic [PW-1:0] etx_packet,
  output logic          etx_rd,
  output logic          etx_rr,
  input  logic          etx_rd_wait,
  input  logic          etx_wr_wait
);

  localparam logic [3:0] HOLD_LIM = 4'(HOLDMAX);

  logic          vld_p0;
  logic          rd_p0;
  logic          rr_p0;
  logic [PW-1:0] pkt_p0;
  logic [3:0]    rr_cnt;
  logic          last_wr;

  logic          hold_wait;
  logic          free;
  logic          other_req;
  logic          rr_win;
  logic          gnt_wr;
  logic          gnt_rd;
  logic          gnt_rr;
  logic          gnt_any;
  logic [PW-1:0] sel_pkt;

  // The held entry only blocks on the stall matching its own type.
  assign hold_wait = rd_p0 ? etx_rd_wait : etx_wr_wait;
  assign free      = nreset & (~vld_p0 | ~hold_wait);
  assign other_req = txwr_fifo_access | txrd_fifo_access;
  assign rr_win    = txrr_fifo_access & ~((rr_cnt >= HOLD_LIM) & other_req);

  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    gnt_rr = 1'b0;
    if (free) begin
      if (rr_win)
        gnt_rr = 1'b1;
      else if (txwr_fifo_access & (~txrd_fifo_access | ~last_wr))
        gnt_wr = 1'b1;
      else if (txrd_fifo_access)
        gnt_rd = 1'b1;
    end
  end

  assign gnt_any = gnt_wr | gnt_rd | gnt_rr;

  always_comb begin
    sel_pkt = txwr_fifo_packet;
    if (gnt_rr)
      sel_pkt = txrr_fifo_packet;
    else if (gnt_rd)
      sel_pkt = txrd_fifo_packet;
  end

  assign txwr_fifo_wait = ~gnt_wr;
  assign txrd_fifo_wait = ~gnt_rd;
  assign txrr_fifo_wait = ~gnt_rr;

  // Stage p0: held output entry plus arbitration state
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      vld_p0  <= 1'b0;
      rd_p0   <= 1'b0;
      rr_p0   <= 1'b0;
      pkt_p0  <= '0;
      rr_cnt  <= 4'd0;
      last_wr <= 1'b0;
    end else begin
      if (free) begin
        vld_p0 <= gnt_any;
        rd_p0  <= gnt_rd;
        rr_p0  <= gnt_rr;
        if (gnt_any)
          pkt_p0 <= sel_pkt;
      end
      if (gnt_rr) begin
        if (!other_req)
          rr_cnt <= 4'd0;
        else if (rr_cnt < HOLD_LIM)
          rr_cnt <= rr_cnt + 4'd1;
      end else if (gnt_wr | gnt_rd) begin
        rr_cnt <= 4'd0;
      end
      if (gnt_wr)
        last_wr <= 1'b1;
      else if (gnt_rd)
        last_wr <= 1'b0;
    end
  end

  assign etx_access = vld_p0;
  assign etx_packet = pkt_p0;
  assign etx_rd     = rd_p0;
  assign etx_rr     = rr_p0;

endmodule

// File: tb/tb_etx_txsched.sv
// Scoreboard bench for etx_txsched: channel sources honour their waits, granted
// packets are queued with their type flags and compared when the output is accepted.
module tb_etx_txsched;
  localparam int PW      = 104;
  localparam int HOLDMAX = 4;
  localparam int WR = 0, RD = 1, RR = 2;

  logic          clk = 1'b0;
  logic          nreset;
  logic          txwr_fifo_access, txrd_fifo_access, txrr_fifo_access;
  logic [PW-1:0] txwr_fifo_packet, txrd_fifo_packet, txrr_fifo_packet;
  logic          txwr_fifo_wait, txrd_fifo_wait, txrr_fifo_wait;
  logic          etx_access, etx_rd, etx_rr;
  logic [PW-1:0] etx_packet;
  logic          etx_rd_wait, etx_wr_wait;

  int total = 0;
  int bad   = 0;
  int seq   = 0;
  logic [PW-1:0] wr_q[$], rd_q[$], rr_q[$];
  logic [PW+1:0] sb_q[$];
  int            gnt_exp_q[$];

  etx_txsched #(.PW(PW), .HOLDMAX(HOLDMAX)) dut (
    .clk(clk), .nreset(nreset),
    .txwr_fifo_access(txwr_fifo_access), .txwr_fifo_packet(txwr_fifo_packet), .txwr_fifo_wait(txwr_fifo_wait),
    .txrd_fifo_access(txrd_fifo_access), .txrd_fifo_packet(txrd_fifo_packet), .txrd_fifo_wait(txrd_fifo_wait),
    .txrr_fifo_access(txrr_fifo_access), .txrr_fifo_packet(txrr_fifo_packet), .txrr_fifo_wait(txrr_fifo_wait),
    .etx_access(etx_access), .etx_packet(etx_packet), .etx_rd(etx_rd), .etx_rr(etx_rr),
    .etx_rd_wait(etx_rd_wait), .etx_wr_wait(etx_wr_wait)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_pkt(input int ch);
    seq++;
    return {8'(ch), 32'(seq), $urandom(), $urandom()};
  endfunction

  task automatic load(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      case (ch)
        WR:      wr_q.push_back(mk_pkt(WR));
        RD:      rd_q.push_back(mk_pkt(RD));
        default: rr_q.push_back(mk_pkt(RR));
      endcase
    end
  endtask

  task automatic expect_grants(input int ch, input int n);
    for (int i = 0; i < n; i++) gnt_exp_q.push_back(ch);
  endtask

  // One clock: drive sources at the falling edge, judge grants and output
  // acceptance just before the rising edge, return at the next falling edge.
  task automatic cycle();
    int   g;
    int   ng;
    logic held_wait;
    logic free;
    logic any_req;
    logic g_req;
    txwr_fifo_access = (wr_q.size() != 0);
    txwr_fifo_packet = txwr_fifo_access ? wr_q[0] : '0;
    txrd_fifo_access = (rd_q.size() != 0);
    txrd_fifo_packet = txrd_fifo_access ? rd_q[0] : '0;
    txrr_fifo_access = (rr_q.size() != 0);
    txrr_fifo_packet = txrr_fifo_access ? rr_q[0] : '0;
    #1;
    held_wait = etx_rd ? etx_rd_wait : etx_wr_wait;
    free      = !etx_access || !held_wait;
    any_req   = txwr_fifo_access || txrd_fifo_access || txrr_fifo_access;
    ng = 0;
    g  = -1;
    if (!txwr_fifo_wait) begin ng++; g = WR; end
    if (!txrd_fifo_wait) begin ng++; g = RD; end
    if (!txrr_fifo_wait) begin ng++; g = RR; end
    check("grant_count", ng, (free && any_req) ? 1 : 0);
    if (etx_access && !held_wait) begin
      if (sb_q.size() == 0) check("sb_underflow", 1, 0);
      else check("out_pkt", {etx_packet, etx_rd, etx_rr}, sb_q.pop_front());
    end
    if (g >= 0) begin
      g_req = (g == WR) ? txwr_fifo_access : (g == RD) ? txrd_fifo_access : txrr_fifo_access;
      check("grant_req", g_req, 1);
      if (gnt_exp_q.size() != 0) check("grant_order", g, gnt_exp_q.pop_front());
      if (g_req) begin
        case (g)
          WR:      sb_q.push_back({wr_q.pop_front(), 2'b00});
          RD:      sb_q.push_back({rd_q.pop_front(), 2'b10});
          default: sb_q.push_back({rr_q.pop_front(), 2'b01});
        endcase
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (wr_q.size() == 0 && rd_q.size() == 0 && rr_q.size() == 0 && !etx_access) break;
      cycle();
    end
    check("drain", {wr_q.size() != 0, rd_q.size() != 0, rr_q.size() != 0, sb_q.size() != 0}, 0);
    check("drain_order", gnt_exp_q.size(), 0);
  endtask

  initial begin
    logic [PW-1:0] held;
    nreset      = 1'b0;
    etx_rd_wait = 1'b0;
    etx_wr_wait = 1'b0;
    txwr_fifo_access = 1'b1; txwr_fifo_packet = mk_pkt(WR);
    txrd_fifo_access = 1'b1; txrd_fifo_packet = mk_pkt(RD);
    txrr_fifo_access = 1'b1; txrr_fifo_packet = mk_pkt(RR);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_access", etx_access, 0);
    check("rst_flags", {etx_rd, etx_rr}, 0);
    check("rst_pkt", etx_packet, 0);
    check("rst_waits", {txwr_fifo_wait, txrd_fifo_wait, txrr_fifo_wait}, 3'b111);
    nreset = 1'b1;

    // Lone write stream: full rate, one cycle latency.
    load(WR, 6);
    expect_grants(WR, 6);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("wr_stream_acc", etx_access, 1);
    end
    held = etx_packet;
    cycle();
    check("idle_access", etx_access, 0);
    check("idle_pkt_hold", etx_packet, held);

    // Write/read contention alternates; write was granted last so read leads.
    load(WR, 6);
    load(RD, 6);
    for (int i = 0; i < 6; i++) begin
      expect_grants(RD, 1);
      expect_grants(WR, 1);
    end
    drain(30);

    // Read responses hold for HOLDMAX slots against a pending write.
    load(RR, 12);
    load(WR, 3);
    for (int i = 0; i < 3; i++) begin
      expect_grants(RR, HOLDMAX);
      expect_grants(WR, 1);
    end
    drain(30);

    // Held read request stalled three cycles by etx_rd_wait.
    load(RD, 1);
    load(WR, 1);
    expect_grants(RD, 1);
    expect_grants(WR, 1);
    cycle();
    etx_rd_wait = 1'b1;
    held = etx_packet;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rd_stall_pkt", etx_packet, held);
      check("rd_stall_rd", etx_rd, 1);
    end
    etx_rd_wait = 1'b0;
    cycle();
    check("after_stall_wr", {etx_access, etx_rd, etx_rr}, 3'b100);
    drain(10);

    // Held writes ignore etx_rd_wait; held read response obeys etx_wr_wait.
    etx_rd_wait = 1'b1;
    load(WR, 4);
    expect_grants(WR, 4);
    drain(10);
    load(RR, 1);
    cycle();
    etx_rd_wait = 1'b0;
    etx_wr_wait = 1'b1;
    held = etx_packet;
    cycle();
    check("rr_stall_pkt", etx_packet, held);
    check("rr_stall_acc", {etx_access, etx_rr}, 2'b11);
    etx_wr_wait = 1'b0;
    drain(10);

    // Reset mid-transfer, then contention resolves from reset state.
    load(WR, 3);
    load(RD, 3);
    cycle();
    cycle();
    check("pre_rst_acc", etx_access, 1);
    #2;
    nreset = 1'b0;
    #1;
    check("async_rst_acc", etx_access, 0);
    check("async_rst_pkt", etx_packet, 0);
    check("async_rst_waits", {txwr_fifo_wait, txrd_fifo_wait, txrr_fifo_wait}, 3'b111);
    wr_q.delete();
    rd_q.delete();
    rr_q.delete();
    sb_q.delete();
    gnt_exp_q.delete();
    @(negedge clk);
    nreset = 1'b1;
    load(WR, 2);
    load(RD, 2);
    expect_grants(WR, 1);
    expect_grants(RD, 1);
    expect_grants(WR, 1);
    expect_grants(RD, 1);
    drain(20);

    // Read responses against a pending read request.
    load(RR, 6);
    load(RD, 1);
    expect_grants(RR, HOLDMAX);
    expect_grants(RD, 1);
    expect_grants(RR, 2);
    drain(20);

    // Random traffic with random downstream stalls.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) load(WR, 1);
      if ($urandom_range(3) == 0) load(RD, 1);
      if ($urandom_range(4) == 0) load(RR, 1);
      etx_rd_wait = ($urandom_range(3) == 0);
      etx_wr_wait = ($urandom_range(3) == 0);
      cycle();
    end
    etx_rd_wait = 1'b0;
    etx_wr_wait = 1'b0;
    drain(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
